// File: rtl/sand_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sand_pkg
//  Purpose  : Shared cell codes and sweep FSM state encoding for the
//             falling-sand sweep controller.
//  Revision : 1.0  initial release
// ============================================================================
package sand_pkg;

  // Cell codes stored in the world RAM. Any other code (walls etc.) is inert.
  localparam int CELL_EMPTY = 0;
  localparam int CELL_SAND  = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    EVAL     = 3'd2,
    WR_BELOW = 3'd3,
    WR_SELF  = 3'd4
  } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/sand_sweep_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sand_sweep_controller
//  Purpose  : Runs one falling-sand physics pass over the cell RAM, scanning
//             from the last cell of the second-to-bottom row down to cell 0.
//             A SAND cell sitting above an EMPTY cell is moved down with two
//             writes. While idle, the RAM write port is lent to the brush.
//  Ports    :
//    clk_i, rst_i            clock, synchronous active-high reset
//    start_i                 level request to begin a sweep
//    draw_valid_i/_address_i/_data_i, draw_ready_o   brush write handshake
//    rd_address_1_o/_2_o     current / below cell read addresses
//    rd_data_1_i/_2_i        registered RAM read data (1-cycle latency)
//    wr_en_o, wr_address_o, wr_data_o   RAM write port
//    busy_o                  sweep in progress
//    done_o                  one-cycle pulse when a sweep completes
//  Revision : 1.0  initial release
// ============================================================================
module sand_sweep_controller
  import sand_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  draw_valid_i,
  input  logic [ADDR_WIDTH-1:0] draw_address_i,
  input  logic [DATA_WIDTH-1:0] draw_data_i,
  output logic                  draw_ready_o,
  output logic [ADDR_WIDTH-1:0] rd_address_1_o,
  output logic [ADDR_WIDTH-1:0] rd_address_2_o,
  input  logic [DATA_WIDTH-1:0] rd_data_1_i,
  input  logic [DATA_WIDTH-1:0] rd_data_2_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_address_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // The bottom row has nothing below it, so the scan starts one row up.
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'((V_RES - 1) * H_RES - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(H_RES);
  localparam logic [DATA_WIDTH-1:0] SAND_CODE  = DATA_WIDTH'(CELL_SAND);
  localparam logic [DATA_WIDTH-1:0] EMPTY_CODE = DATA_WIDTH'(CELL_EMPTY);

  sweep_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;

  logic [ADDR_WIDTH-1:0] below_addr;
  logic                  draw_grant;
  logic                  cell_falls;

  assign below_addr = addr_q + ROW_STRIDE;
  // Brush owns the write port only while idle; masked during reset.
  assign draw_grant = (state_q == IDLE) && draw_valid_i && !rst_i;
  assign cell_falls = (rd_data_1_i == SAND_CODE) && (rd_data_2_i == EMPTY_CODE);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Brush wins over start; a held start is taken on a later idle cycle.
        if (!draw_valid_i && start_i) begin
          addr_d  = START_ADDR;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end

      ISSUE: state_d = EVAL;

      EVAL: begin
        if (cell_falls) begin
          state_d = WR_BELOW;
        end else if (addr_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q - 1'b1;
          state_d = ISSUE;
        end
      end

      WR_BELOW: state_d = WR_SELF;

      WR_SELF: begin
        if (addr_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q - 1'b1;
          state_d = ISSUE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // RAM write port: brush in IDLE, the two halves of a move otherwise.
  // The move writes are not masked by reset, so a reset landing in WR_BELOW
  // still commits that write (the grain is duplicated, never lost).
  // --------------------------------------------------------------------------
  always_comb begin
    wr_en_o      = 1'b0;
    wr_address_o = '0;
    wr_data_o    = '0;
    case (state_q)
      IDLE: begin
        if (draw_grant) begin
          wr_en_o      = 1'b1;
          wr_address_o = draw_address_i;
          wr_data_o    = draw_data_i;
        end
      end
      WR_BELOW: begin
        wr_en_o      = 1'b1;
        wr_address_o = below_addr;
        wr_data_o    = SAND_CODE;
      end
      WR_SELF: begin
        wr_en_o      = 1'b1;
        wr_address_o = addr_q;
        wr_data_o    = EMPTY_CODE;
      end
      default: ;
    endcase
  end

  assign draw_ready_o   = draw_grant;
  assign rd_address_1_o = addr_q;
  assign rd_address_2_o = below_addr;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule
`default_nettype wire

// File: doc/sand_sweep_controller.md
Name: sand_sweep_controller

Overview:
- Sequences one physics pass ("sweep") of the falling-sand world over the cell RAM (`register_file_dual_port_read`: one write port, two registered read ports, 1-cycle read latency).
- For each cell, read port 1 fetches the cell and read port 2 fetches the cell directly below. A SAND cell above an EMPTY cell is swapped down using two write cycles.
- The block also arbitrates the RAM write port between the sweep engine and a brush (draw) requester.

Parameters:
- H_RES, 640, cells per row
- V_RES, 480, rows per frame
- ADDR_WIDTH, 19, cell RAM address width (must hold H_RES*V_RES-1)
- DATA_WIDTH, 8, cell code width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  level request to begin a sweep
- draw_valid_i  in  1  brush write request
- draw_address_i  in  ADDR_WIDTH  brush target cell
- draw_data_i  in  DATA_WIDTH  brush cell code
- draw_ready_o  out  1  brush write accepted this cycle
- rd_address_1_o  out  ADDR_WIDTH  current cell address to RAM
- rd_address_2_o  out  ADDR_WIDTH  below-cell address to RAM
- rd_data_1_i  in  DATA_WIDTH  current cell data, registered by RAM
- rd_data_2_i  in  DATA_WIDTH  below cell data, registered by RAM
- wr_en_o  out  1  RAM write enable
- wr_address_o  out  ADDR_WIDTH  RAM write address
- wr_data_o  out  DATA_WIDTH  RAM write data
- busy_o  out  1  sweep in progress
- done_o  out  1  one-cycle pulse, sweep complete

Behaviour:

Clock and reset:
- Single clock `clk_i`; reset `rst_i` is synchronous and active-high.
- On reset: state IDLE, addr = 0, wr_en_o=0, wr_address_o=0, wr_data_o=0, busy_o=0, done_o=0.
- After reset, draw_ready_o follows its IDLE rule. It is forced to 0 during the reset cycle.
- Reset mid-sweep aborts immediately. No further write is issued and done_o is not pulsed.

Scan order:
- Single descending address counter `addr`.
- START_ADDR = (V_RES-1)*H_RES-1, the last cell of the second-to-bottom row; addr runs down to 0.
- The bottom row is never a current cell.
- rd_address_1_o = addr; rd_address_2_o = addr+H_RES (ADDR_WIDTH arithmetic; this sum never exceeds H_RES*V_RES-1).
- Because the scan runs bottom-up, a grain moved down lands on an already-visited cell. Each grain falls at most one row per sweep.

FSM states:
- IDLE:
  - If draw_valid_i=1: draw_ready_o=1, and in the same cycle wr_en_o=1, wr_address_o=draw_address_i, wr_data_o=draw_data_i.
  - Else if start_i=1: addr<=START_ADDR, busy_o<=1, go to ISSUE.
  - Draw takes priority over start in the same cycle; start is level-sensitive and is taken on a later IDLE cycle.
- ISSUE: read addresses valid. Go to EVAL.
- EVAL: rd_data_*_i are valid.
  - If rd_data_1_i==CELL_SAND and rd_data_2_i==CELL_EMPTY: go to WR_BELOW.
  - Else: advance.
- WR_BELOW: wr_en_o=1, wr_address_o=addr+H_RES, wr_data_o=CELL_SAND. Go to WR_SELF.
- WR_SELF: wr_en_o=1, wr_address_o=addr, wr_data_o=CELL_EMPTY. Advance.
- Advance:
  - If addr==0: go to IDLE, busy_o<=0, done_o=1 for exactly one cycle (the first IDLE cycle).
  - Else: addr<=addr-1, go to ISSUE.
- Any unlisted state goes to IDLE.

Timing and arbitration:
- Per cell: 2 cycles if the cell stays, 4 cycles if it moves.
- wr_en_o is 0 in ISSUE and EVAL.
- draw_ready_o=0 in every state except IDLE. The brush never interleaves with a sweep, so reads never see a half-applied write.
- Cell codes other than SAND and EMPTY (walls etc.) never move and never act as empty.
- A 1xN world (V_RES=1) is illegal.

Decomposition:
- Package `sand_pkg`:
  - cell codes CELL_EMPTY=0, CELL_SAND=1
  - state enum typedef sweep_state_t {IDLE, ISSUE, EVAL, WR_BELOW, WR_SELF}
- No sub-module. The block is a single FSM plus address counter that instantiates nothing. The bench pairs it with `register_file_dual_port_read`.

Test Plan (H_RES=4, V_RES=3, so START_ADDR=7, RAM zero except as noted):
- Empty world, start_i=1 for one cycle -> 8 cells x 2 cycles; busy_o high 16 cycles; done_o pulses once; wr_en_o never asserted.
- SAND at addr 5, empty below (9) -> one sweep writes 9<=SAND then 5<=EMPTY on consecutive cycles; RAM[5]=0, RAM[9]=1.
- SAND at 1 and 5, nothing else -> after sweep 1: cells 5 and 9 hold SAND, cell 1 empty. Sweep 2 leaves RAM unchanged with no writes (5 is resting on 9).
- Wall code 2 at 9, SAND at 5 -> no writes; cell 5 remains SAND.
- draw_valid_i held during a sweep (addr 3, data 1) -> draw_ready_o=0 until done. The write lands in the first IDLE cycle. A simultaneous start_i=1 starts the next sweep one cycle later.
- rst_i asserted in the WR_BELOW cycle of the SAND-at-5 case -> busy_o=0, wr_en_o=0 the next cycle, no done_o. RAM[9]=SAND and RAM[5]=SAND (the partial move is accepted).
